// File: rtl/pe_bus_pkg.sv
// Shared types and widths for the PE shared-bus arbiter.
package pe_bus_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned DEF_NUM_PE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_e;

  // Owner index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_bus_arbiter_if.sv
// Bus-side bundle between the PE bus interfaces, the arbiter and the shared slaves.
// Carries bus_timeout only when PE_BUS_TIMEOUT_EN is defined.
interface pe_bus_arbiter_if
  import pe_bus_pkg::*;
#(
  parameter int unsigned NUM_PE = DEF_NUM_PE
);

  localparam int unsigned IDX_W = idx_w(NUM_PE);

  logic [NUM_PE-1:0]        bus_request;
  logic [NUM_PE-1:0]        grant;

  logic [NUM_PE*ADDR_W-1:0] m_mem_address;
  logic [NUM_PE*ADDR_W-1:0] m_result_out;
  logic [NUM_PE*ADDR_W-1:0] m_pc_out;
  logic [NUM_PE*REG_W-1:0]  m_rs1;
  logic [NUM_PE*REG_W-1:0]  m_rs2;
  logic [NUM_PE*REG_W-1:0]  m_rd;
  logic [NUM_PE-1:0]        m_reg_select;
  logic [NUM_PE-1:0]        m_mem_read;
  logic [NUM_PE-1:0]        m_mem_write;
  logic [NUM_PE-1:0]        m_rd_write;
  logic [NUM_PE-1:0]        m_read_en;

  logic [ADDR_W-1:0]        s_mem_address;
  logic [ADDR_W-1:0]        s_result_out;
  logic [ADDR_W-1:0]        s_pc_out;
  logic [REG_W-1:0]         s_rs1;
  logic [REG_W-1:0]         s_rs2;
  logic [REG_W-1:0]         s_rd;
  logic                     s_reg_select;
  logic                     s_mem_read;
  logic                     s_mem_write;
  logic                     s_rd_write;
  logic                     s_read_en;

  logic                     mem_ack;
  logic                     data_ready;
  logic [NUM_PE-1:0]        mem_ack_pe;
  logic [NUM_PE-1:0]        data_ready_pe;

  logic [IDX_W-1:0]         owner_id;
  logic                     bus_busy;
`ifdef PE_BUS_TIMEOUT_EN
  logic                     bus_timeout;
`endif

  // Arbiter side.
  modport master (
    input  bus_request,
    input  m_mem_address, m_result_out, m_pc_out,
    input  m_rs1, m_rs2, m_rd,
    input  m_reg_select, m_mem_read, m_mem_write, m_rd_write, m_read_en,
    input  mem_ack, data_ready,
`ifdef PE_BUS_TIMEOUT_EN
    output bus_timeout,
`endif
    output grant,
    output s_mem_address, s_result_out, s_pc_out,
    output s_rs1, s_rs2, s_rd,
    output s_reg_select, s_mem_read, s_mem_write, s_rd_write, s_read_en,
    output mem_ack_pe, data_ready_pe,
    output owner_id, bus_busy
  );

  // PE / slave side.
  modport slave (
    output bus_request,
    output m_mem_address, m_result_out, m_pc_out,
    output m_rs1, m_rs2, m_rd,
    output m_reg_select, m_mem_read, m_mem_write, m_rd_write, m_read_en,
    output mem_ack, data_ready,
`ifdef PE_BUS_TIMEOUT_EN
    input  bus_timeout,
`endif
    input  grant,
    input  s_mem_address, s_result_out, s_pc_out,
    input  s_rs1, s_rs2, s_rd,
    input  s_reg_select, s_mem_read, s_mem_write, s_rd_write, s_read_en,
    input  mem_ack_pe, data_ready_pe,
    input  owner_id, bus_busy
  );

endinterface

// File: rtl/pe_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping mod N.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned cand;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[IDX_W'(cand)]) begin
        valid_o                  = 1'b1;
        onehot_o[IDX_W'(cand)]   = 1'b1;
        idx_o                    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pe_bus_arbiter.sv
// Round-robin shared-bus arbiter and owner multiplexer for NUM_PE bus masters.
// Optional WAIT watchdog with bus_timeout pulse: define PE_BUS_TIMEOUT_EN.
module pe_bus_arbiter
  import pe_bus_pkg::*;
#(
  parameter int unsigned NUM_PE         = DEF_NUM_PE,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  pe_bus_arbiter_if.master bus
);

  localparam int unsigned IDX_W = idx_w(NUM_PE);

  if (NUM_PE < 2 || NUM_PE > 16 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("pe_bus_arbiter: NUM_PE must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  state_e            state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_d;
  logic [NUM_PE-1:0] grant_q;
  logic              busy_q;

  logic [NUM_PE-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              done;
  logic              tmo_hit;

  rr_picker #(
    .N     (NUM_PE),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (bus.bus_request),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign done     = bus.mem_ack | bus.data_ready;
  assign rr_ptr_d = (owner_q == IDX_W'(NUM_PE - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef PE_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  assign tmo_hit         = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign bus.bus_timeout = tmo_q;

  // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q     <= (state_q == WAIT) && !done && tmo_hit;
      tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Arbitration FSM; grant, owner and busy are registered with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            owner_q <= pick_idx;
            grant_q <= pick_onehot;
            busy_q  <= 1'b1;
          end
        end
        GRANT: state_q <= ISSUE;
        ISSUE: begin
          if (done) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b0;
          end else begin
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (done || tmo_hit) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner_id = owner_q;
  assign bus.bus_busy = busy_q;

  // Bus steering is a live mux: the PE's latched fields only become valid after
  // the GRANT edge, so a registered copy would capture stale values.
  always_comb begin
    int unsigned aoff;
    int unsigned roff;
    aoff               = ADDR_W * 32'(owner_q);
    roff               = REG_W * 32'(owner_q);
    bus.s_mem_address  = '0;
    bus.s_result_out   = '0;
    bus.s_pc_out       = '0;
    bus.s_rs1          = '0;
    bus.s_rs2          = '0;
    bus.s_rd           = '0;
    bus.s_reg_select   = 1'b0;
    bus.s_mem_read     = 1'b0;
    bus.s_mem_write    = 1'b0;
    bus.s_rd_write     = 1'b0;
    bus.s_read_en      = 1'b0;
    bus.mem_ack_pe     = '0;
    bus.data_ready_pe  = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      bus.s_mem_address           = bus.m_mem_address[aoff +: ADDR_W];
      bus.s_result_out            = bus.m_result_out[aoff +: ADDR_W];
      bus.s_pc_out                = bus.m_pc_out[aoff +: ADDR_W];
      bus.s_rs1                   = bus.m_rs1[roff +: REG_W];
      bus.s_rs2                   = bus.m_rs2[roff +: REG_W];
      bus.s_rd                    = bus.m_rd[roff +: REG_W];
      bus.s_reg_select            = bus.m_reg_select[owner_q];
      bus.mem_ack_pe[owner_q]     = bus.mem_ack;
      bus.data_ready_pe[owner_q]  = bus.data_ready;
    end
    // Strobes only in ISSUE so a PE's stale latches never re-fire in WAIT.
    if (state_q == ISSUE) begin
      bus.s_mem_read  = bus.m_mem_read[owner_q];
      bus.s_mem_write = bus.m_mem_write[owner_q];
      bus.s_rd_write  = bus.m_rd_write[owner_q];
      bus.s_read_en   = bus.m_read_en[owner_q];
    end
  end

endmodule
